mips_pipe_main: RTL and testbench

- 5-stage in-order MIPS-subset core: IF, ID, EX, MEM, WB.
- Fetches from an externally supplied instruction array.
- Initial register-file contents are loaded from an externally supplied array.
- Holds its own data memory; no architectural outputs, so the register file and data memory are checked through hierarchical names.
- Top of the CPU subsystem; used standalone under a clocked bench.

---
 rtl/mips_pipe_pkg.sv | 70 +++++++
 rtl/mips_hazard_unit.sv | 77 +++++++
 rtl/mips_pipe_main.sv | 251 +++++++++++++++++++++++++
 tb/tb_mips_pipe_main.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types for the mips_pipe_main core: opcode/funct codes,
// ALU/forward selects and the four pipeline-register bundles.
package mips_pipe_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    localparam logic [1:0] FWD_NONE  = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              alu_src;
        alu_op_e           alu_op;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic [WORD_W-1:0] rs_val;
        logic [WORD_W-1:0] rt_val;
        logic [WORD_W-1:0] imm;
        logic [WORD_W-1:0] pc;
    } id_ex_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [4:0]        dest;
        logic [WORD_W-1:0] alu_res;
        logic [WORD_W-1:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic              reg_write;
        logic [4:0]        dest;
        logic [WORD_W-1:0] wdata;
    } mem_wb_t;

    function automatic logic [WORD_W-1:0] sext16(input logic [15:0] v);
        return {{(WORD_W-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// Combinational hazard unit: operand forward selects, stall and flush.
// Ports: i_id_* (ID sources), i_ex_* (ID/EX), i_mem_* (EX/MEM),
//   i_wb_* (MEM/WB); o_stall, o_flush, o_fwd_a/o_fwd_b.
// MAIN_FWD_EN selects bypassing (load-use stall only) vs full interlock.
module mips_hazard_unit
    import mips_pipe_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_use_rs,
    input  logic       i_id_use_rt,
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_ex_dest,
    input  logic       i_ex_reg_write,
    input  logic       i_ex_mem_read,
    input  logic       i_ex_taken,
    input  logic [4:0] i_mem_dest,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_wb_dest,
    input  logic       i_wb_reg_write,
    output logic       o_stall,
    output logic       o_flush,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    logic w_hit_ex;

    assign w_hit_ex = (i_ex_dest != 5'd0) &&
                      ((i_id_use_rs && i_id_rs == i_ex_dest) ||
                       (i_id_use_rt && i_id_rt == i_ex_dest));

    // A taken branch squashes whatever ID would have stalled on.
    assign o_flush = i_ex_taken;

`ifdef MAIN_FWD_EN
    logic w_unused_fwd;
    assign w_unused_fwd = i_ex_reg_write;

    assign o_stall = i_ex_mem_read && w_hit_ex;

    // EX/MEM is younger than MEM/WB, so it is checked first.
    always_comb begin
        o_fwd_a = FWD_NONE;
        o_fwd_b = FWD_NONE;
        if (i_mem_reg_write && i_mem_dest != 5'd0 &&
            i_mem_dest == i_ex_rs)
            o_fwd_a = FWD_EXMEM;
        else if (i_wb_reg_write && i_wb_dest != 5'd0 &&
                 i_wb_dest == i_ex_rs)
            o_fwd_a = FWD_MEMWB;
        if (i_mem_reg_write && i_mem_dest != 5'd0 &&
            i_mem_dest == i_ex_rt)
            o_fwd_b = FWD_EXMEM;
        else if (i_wb_reg_write && i_wb_dest != 5'd0 &&
                 i_wb_dest == i_ex_rt)
            o_fwd_b = FWD_MEMWB;
    end
`else
    logic w_hit_mem;
    logic w_unused_fwd;

    assign w_hit_mem = (i_mem_dest != 5'd0) &&
                       ((i_id_use_rs && i_id_rs == i_mem_dest) ||
                        (i_id_use_rt && i_id_rt == i_mem_dest));

    // WB producers reach ID through the register-file write-through.
    assign o_stall = (i_ex_reg_write && w_hit_ex) ||
                     (i_mem_reg_write && w_hit_mem);
    assign o_fwd_a = FWD_NONE;
    assign o_fwd_b = FWD_NONE;
    assign w_unused_fwd = ^{i_ex_rs, i_ex_rt, i_ex_mem_read,
                            i_wb_dest, i_wb_reg_write};
`endif

endmodule

// File: rtl/mips_pipe_main.sv
// 5-stage MIPS-subset core (add/sub/and/or/slt, lw, sw, beq).
// Ports: clk, rst (sync, active-low), instMemory (word-indexed
//   program), regMem (register image loaded during reset).
// Define MAIN_FWD_EN to enable the bypass network.
module mips_pipe_main
    import mips_pipe_pkg::*;
#(
    parameter int IMEM_DEPTH = 65536,
    parameter int DMEM_DEPTH = 4096,
    parameter int XLEN       = 32
) (
    input logic            clk,
    input logic            rst,
    input logic [XLEN-1:0] instMemory [IMEM_DEPTH],
    input logic [XLEN-1:0] regMem [32]
);

    localparam int PC_W  = $clog2(IMEM_DEPTH);
    localparam int DM_AW = $clog2(DMEM_DEPTH);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_br_target;

    if_id_t  r_if_id;
    id_ex_t  r_id_ex;
    id_ex_t  w_dec;
    ex_mem_t r_ex_mem;
    ex_mem_t w_ex_out;
    mem_wb_t r_mem_wb;
    mem_wb_t w_mem_out;

    logic [XLEN-1:0] r_regfile [32];
    logic [XLEN-1:0] r_dmem [DMEM_DEPTH];

    logic            w_stall;
    logic            w_flush;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;
    logic            w_use_rs;
    logic            w_use_rt;
    logic            w_taken;

    logic [5:0]      w_op;
    logic [5:0]      w_fn;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_rs_val;
    logic [XLEN-1:0] w_rt_val;
    logic            w_unused_shamt;

    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_rt_fwd;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_res;
    logic [DM_AW-1:0] w_dm_addr;

    // ---------------- IF ----------------
    assign w_pc_next = (r_pc == PC_W'(IMEM_DEPTH - 1)) ?
                       '0 : r_pc + 1'b1;

    // ---------------- ID ----------------
    assign w_op = r_if_id.instr[31:26];
    assign w_rs = r_if_id.instr[25:21];
    assign w_rt = r_if_id.instr[20:16];
    assign w_rd = r_if_id.instr[15:11];
    assign w_fn = r_if_id.instr[5:0];
    assign w_unused_shamt = ^r_if_id.instr[10:6];

    // Write-through: a WB write lands in the same cycle's ID read.
    assign w_rs_val = (r_mem_wb.reg_write && r_mem_wb.dest != 5'd0 &&
                       r_mem_wb.dest == w_rs) ?
                      r_mem_wb.wdata : r_regfile[w_rs];
    assign w_rt_val = (r_mem_wb.reg_write && r_mem_wb.dest != 5'd0 &&
                       r_mem_wb.dest == w_rt) ?
                      r_mem_wb.wdata : r_regfile[w_rt];

    always_comb begin
        w_dec        = '0;
        w_use_rs     = 1'b0;
        w_use_rt     = 1'b0;
        w_dec.rs     = w_rs;
        w_dec.rt     = w_rt;
        w_dec.rs_val = w_rs_val;
        w_dec.rt_val = w_rt_val;
        w_dec.imm    = sext16(r_if_id.instr[15:0]);
        w_dec.pc     = r_if_id.pc;
        unique case (1'b1)
            (w_op == OP_RTYPE): begin
                w_dec.dest = w_rd;
                case (w_fn)
                    FN_ADD: w_dec.alu_op = ALU_ADD;
                    FN_SUB: w_dec.alu_op = ALU_SUB;
                    FN_AND: w_dec.alu_op = ALU_AND;
                    FN_OR:  w_dec.alu_op = ALU_OR;
                    FN_SLT: w_dec.alu_op = ALU_SLT;
                    default: w_dec.alu_op = ALU_ADD;
                endcase
                if (w_fn == FN_ADD || w_fn == FN_SUB ||
                    w_fn == FN_AND || w_fn == FN_OR ||
                    w_fn == FN_SLT) begin
                    w_dec.reg_write = 1'b1;
                    w_use_rs        = 1'b1;
                    w_use_rt        = 1'b1;
                end
            end
            (w_op == OP_LW): begin
                w_dec.dest      = w_rt;
                w_dec.reg_write = 1'b1;
                w_dec.mem_read  = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_use_rs        = 1'b1;
            end
            (w_op == OP_SW): begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_use_rs        = 1'b1;
                w_use_rt        = 1'b1;
            end
            (w_op == OP_BEQ): begin
                w_dec.branch = 1'b1;
                w_use_rs     = 1'b1;
                w_use_rt     = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- EX ----------------
    always_comb begin
        case (w_fwd_a)
            FWD_EXMEM: w_alu_a = r_ex_mem.alu_res;
            FWD_MEMWB: w_alu_a = r_mem_wb.wdata;
            default:   w_alu_a = r_id_ex.rs_val;
        endcase
        case (w_fwd_b)
            FWD_EXMEM: w_rt_fwd = r_ex_mem.alu_res;
            FWD_MEMWB: w_rt_fwd = r_mem_wb.wdata;
            default:   w_rt_fwd = r_id_ex.rt_val;
        endcase
    end

    assign w_alu_b = r_id_ex.alu_src ? r_id_ex.imm : w_rt_fwd;

    always_comb begin
        unique case (r_id_ex.alu_op)
            ALU_ADD: w_alu_res = w_alu_a + w_alu_b;
            ALU_SUB: w_alu_res = w_alu_a - w_alu_b;
            ALU_AND: w_alu_res = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_res = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_res = {{(XLEN-1){1'b0}},
                                  $signed(w_alu_a) < $signed(w_alu_b)};
            default: w_alu_res = '0;
        endcase
    end

    assign w_taken = r_id_ex.branch && (w_alu_a == w_rt_fwd);
    assign w_br_target = PC_W'(r_id_ex.pc + r_id_ex.imm + 32'd1);

    always_comb begin
        w_ex_out            = '0;
        w_ex_out.reg_write  = r_id_ex.reg_write;
        w_ex_out.mem_read   = r_id_ex.mem_read;
        w_ex_out.mem_write  = r_id_ex.mem_write;
        w_ex_out.dest       = r_id_ex.dest;
        w_ex_out.alu_res    = w_alu_res;
        w_ex_out.store_data = w_rt_fwd;
    end

    // ---------------- MEM ----------------
    assign w_dm_addr = r_ex_mem.alu_res[DM_AW-1:0];

    always_comb begin
        w_mem_out           = '0;
        w_mem_out.reg_write = r_ex_mem.reg_write;
        w_mem_out.dest      = r_ex_mem.dest;
        w_mem_out.wdata     = r_ex_mem.mem_read ?
                              r_dmem[w_dm_addr] : r_ex_mem.alu_res;
    end

    mips_hazard_unit u_hazard (
        .i_id_rs        (w_rs),
        .i_id_rt        (w_rt),
        .i_id_use_rs    (w_use_rs),
        .i_id_use_rt    (w_use_rt),
        .i_ex_rs        (r_id_ex.rs),
        .i_ex_rt        (r_id_ex.rt),
        .i_ex_dest      (r_id_ex.dest),
        .i_ex_reg_write (r_id_ex.reg_write),
        .i_ex_mem_read  (r_id_ex.mem_read),
        .i_ex_taken     (w_taken),
        .i_mem_dest     (r_ex_mem.dest),
        .i_mem_reg_write(r_ex_mem.reg_write),
        .i_wb_dest      (r_mem_wb.dest),
        .i_wb_reg_write (r_mem_wb.reg_write),
        .o_stall        (w_stall),
        .o_flush        (w_flush),
        .o_fwd_a        (w_fwd_a),
        .o_fwd_b        (w_fwd_b)
    );

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc     <= '0;
            r_if_id  <= '0;
            r_id_ex  <= '0;
            r_ex_mem <= '0;
            r_mem_wb <= '0;
        end else begin
            r_ex_mem <= w_ex_out;
            r_mem_wb <= w_mem_out;
            if (w_flush) begin
                r_pc    <= w_br_target;
                r_if_id <= '0;
                r_id_ex <= '0;
            end else if (w_stall) begin
                r_id_ex <= '0;
            end else begin
                r_pc          <= w_pc_next;
                r_if_id.pc    <= WORD_W'(r_pc);
                r_if_id.instr <= instMemory[r_pc];
                r_id_ex       <= w_dec;
            end
        end
    end

    // ---------------- register file (WB) ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                r_regfile[i] <= regMem[i];
            r_regfile[0] <= '0;
        end else if (r_mem_wb.reg_write == 1'b1 &&
                     r_mem_wb.dest != 5'd0) begin
            r_regfile[r_mem_wb.dest] <= r_mem_wb.wdata;
        end
    end

    // ---------------- data memory ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++)
                r_dmem[i] <= '0;
        end else if (r_ex_mem.mem_write == 1'b1) begin
            r_dmem[w_dm_addr] <= r_ex_mem.store_data;
        end
    end

endmodule

// File: tb/tb_mips_pipe_main.sv
// Bench for mips_pipe_main: directed programs plus random programs,
// each compared against an instruction-level interpreter.
module tb_mips_pipe_main;

    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADD  = 6'b100000;
    localparam logic [5:0] T_SUB  = 6'b100010;
    localparam logic [5:0] T_AND  = 6'b100100;
    localparam logic [5:0] T_OR   = 6'b100101;
    localparam logic [5:0] T_SLT  = 6'b101010;

`ifdef MAIN_FWD_EN
    localparam int STALL_A = 1;
    localparam int STALL_B = 1;
    localparam int STALL_C = 0;
`else
    localparam int STALL_A = 2;
    localparam int STALL_B = 4;
    localparam int STALL_C = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem [65536];
    logic [31:0] rmem [32];

    logic [31:0] m_reg [32];
    logic [31:0] m_dmem [4096];

    int n_chk  = 0;
    int n_pass = 0;
    int n_stall;

    always #5 clk = ~clk;

    mips_pipe_main dut (
        .clk       (clk),
        .rst       (rst),
        .instMemory(imem),
        .regMem    (rmem)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn,
        input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op,
        input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run(input int cycles);
        n_stall = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (dut.w_stall && !dut.w_flush) n_stall++;
        end
    endtask

    // Architectural interpreter: one instruction per step, in order.
    task automatic model_run(input int len);
        int pc, steps;
        logic [31:0] w, a, b, imm, ea;
        for (int i = 0; i < 32; i++) m_reg[i] = rmem[i];
        m_reg[0] = 32'd0;
        for (int i = 0; i < 4096; i++) m_dmem[i] = 32'd0;
        pc = 0;
        steps = 0;
        while (pc < len && steps < 1000) begin
            w   = imem[pc];
            a   = m_reg[w[25:21]];
            b   = m_reg[w[20:16]];
            imm = {{16{w[15]}}, w[15:0]};
            ea  = a + imm;
            pc  = pc + 1;
            steps++;
            if (w[31:26] == 6'b000000) begin
                if (w[5:0] == T_ADD) m_reg[w[15:11]] = a + b;
                if (w[5:0] == T_SUB) m_reg[w[15:11]] = a - b;
                if (w[5:0] == T_AND) m_reg[w[15:11]] = a & b;
                if (w[5:0] == T_OR)  m_reg[w[15:11]] = a | b;
                if (w[5:0] == T_SLT)
                    m_reg[w[15:11]] = ($signed(a) < $signed(b)) ? 1 : 0;
            end else if (w[31:26] == T_LW) begin
                m_reg[w[20:16]] = m_dmem[ea[11:0]];
            end else if (w[31:26] == T_SW) begin
                m_dmem[ea[11:0]] = b;
            end else if (w[31:26] == T_BEQ) begin
                if (a == b) pc = pc + int'($signed(imm));
            end
            m_reg[0] = 32'd0;
        end
    endtask

    task automatic compare_all(input string name);
        int nd;
        for (int r = 0; r < 32; r++)
            chk($sformatf("%s_r%0d", name, r), dut.r_regfile[r], m_reg[r]);
        nd = 0;
        for (int i = 0; i < 4096; i++)
            if (dut.r_dmem[i] !== m_dmem[i]) nd++;
        chk($sformatf("%s_dmem_diff", name), nd, 0);
    endtask

    task automatic directed(input string name, input int len,
                            input int cycles);
        do_reset();
        run(cycles);
        model_run(len);
        compare_all(name);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0]  fns [5];
        int          k;
        logic [4:0]  a, b, c;
        logic [15:0] imm;
        fns[0] = T_ADD; fns[1] = T_SUB; fns[2] = T_AND;
        fns[3] = T_OR;  fns[4] = T_SLT;
        k   = $urandom_range(0, 9);
        a   = 5'($urandom_range(0, 7));
        b   = 5'($urandom_range(0, 7));
        c   = 5'($urandom_range(0, 7));
        imm = 16'($urandom_range(0, 31)) - 16'd16;
        if (k <= 3) return enc_r(fns[$urandom_range(0, 4)], c, a, b);
        if (k <= 5) return enc_i(T_LW, b, a, imm);
        if (k <= 7) return enc_i(T_SW, b, a, imm);
        if (k == 8)
            return enc_i(T_BEQ, 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)),
                         16'($urandom_range(0, 3)));
        return {6'b111111, 26'($urandom)};
    endfunction

    initial begin
        logic [31:0] acc;
        int len;

        // Reset: image copied, R0 forced to zero, memory cleared.
        clear_imem();
        for (int i = 0; i < 32; i++) rmem[i] = i;
        rmem[0] = 32'hdeadbeef;
        imem[0] = enc_i(T_SW, 5'd1, 5'd0, 16'd7);
        imem[1] = enc_r(T_ADD, 5'd5, 5'd1, 5'd1);
        do_reset();
        chk("rst_pc", 32'(dut.r_pc), 32'd0);
        chk("rst_r5", dut.r_regfile[5], 32'd5);
        chk("rst_r0", dut.r_regfile[0], 32'd0);
        acc = 32'd0;
        for (int i = 0; i < 4096; i++) acc = acc | dut.r_dmem[i];
        chk("rst_dmem", acc, 32'd0);

        // Store/load then dependent add.
        clear_imem();
        imem[0] = enc_i(T_SW, 5'd1, 5'd0, 16'd1000);
        imem[1] = enc_i(T_SW, 5'd1, 5'd0, 16'd2000);
        imem[2] = enc_i(T_LW, 5'd21, 5'd0, 16'd1000);
        imem[3] = enc_i(T_LW, 5'd22, 5'd0, 16'd2000);
        imem[4] = enc_r(T_ADD, 5'd23, 5'd21, 5'd22);
        directed("A", 5, 20);
        chk("A_d1000", dut.r_dmem[1000], 32'd1);
        chk("A_d2000", dut.r_dmem[2000], 32'd1);
        chk("A_r23", dut.r_regfile[23], 32'd2);
        chk("A_stalls", n_stall, STALL_A);

        // Same with R2 and a store of the fresh sum.
        clear_imem();
        imem[0] = enc_i(T_SW, 5'd2, 5'd0, 16'd1000);
        imem[1] = enc_i(T_SW, 5'd2, 5'd0, 16'd2000);
        imem[2] = enc_i(T_LW, 5'd21, 5'd0, 16'd1000);
        imem[3] = enc_i(T_LW, 5'd22, 5'd0, 16'd2000);
        imem[4] = enc_r(T_ADD, 5'd23, 5'd21, 5'd22);
        imem[5] = enc_i(T_SW, 5'd23, 5'd0, 16'd3000);
        directed("B", 6, 24);
        chk("B_d3000", dut.r_dmem[3000], 32'd4);
        chk("B_stalls", n_stall, STALL_B);

        // Back-to-back ALU dependencies.
        clear_imem();
        imem[0] = enc_r(T_ADD, 5'd10, 5'd8, 5'd9);
        imem[1] = enc_r(T_SUB, 5'd11, 5'd10, 5'd8);
        imem[2] = enc_r(T_SLT, 5'd12, 5'd8, 5'd11);
        directed("C", 3, 16);
        chk("C_r10", dut.r_regfile[10], 32'd17);
        chk("C_r11", dut.r_regfile[11], 32'd9);
        chk("C_r12", dut.r_regfile[12], 32'd1);
        chk("C_stalls", n_stall, STALL_C);

        // Taken branch squashes the two following adds.
        clear_imem();
        imem[0] = enc_i(T_BEQ, 5'd0, 5'd0, 16'd2);
        imem[1] = enc_r(T_ADD, 5'd5, 5'd5, 5'd5);
        imem[2] = enc_r(T_ADD, 5'd5, 5'd5, 5'd5);
        imem[3] = enc_r(T_ADD, 5'd6, 5'd5, 5'd5);
        directed("D", 4, 16);
        chk("D_r5", dut.r_regfile[5], 32'd5);
        chk("D_r6", dut.r_regfile[6], 32'd10);

        // Reset while a lw sits in MEM.
        clear_imem();
        imem[0] = enc_i(T_LW, 5'd3, 5'd0, 16'd5);
        imem[1] = enc_r(T_ADD, 5'd4, 5'd1, 5'd1);
        for (int i = 0; i < 32; i++) rmem[i] = i;
        do_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) rmem[i] = i + 100;
        @(posedge clk);
        #1;
        chk("E_pc", 32'(dut.r_pc), 32'd0);
        chk("E_r3", dut.r_regfile[3], 32'd103);
        chk("E_r4", dut.r_regfile[4], 32'd104);
        chk("E_r0", dut.r_regfile[0], 32'd0);
        chk("E_d5", dut.r_dmem[5], 32'd0);
        rst = 1'b1;

        // Random programs.
        for (int t = 0; t < 12; t++) begin
            clear_imem();
            for (int i = 0; i < 32; i++)
                rmem[i] = (i < 8) ? 32'($urandom_range(0, 31)) : $urandom;
            len = 20;
            for (int k = 0; k < len; k++) imem[k] = gen_instr();
            directed($sformatf("rnd%0d", t), len, 5 * len + 10);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
